// File: rtl/console_mmio_ctrl.sv
// console_mmio_ctrl: memory-mapped console port on the data-memory bus.
// Stores to TERM_ADDR are buffered in a DEPTH-entry FIFO and drained to a
// valid/ready sink. STAT_ADDR reads back count/empty/full/drop counter and
// accepts flush / drop-clear control writes.
// Build option: define CONSOLE_DROP_EN to drop stores into a full FIFO
// (counted in a saturating 16-bit counter) instead of stalling the pipeline.
module console_mmio_ctrl #(
  parameter logic [31:0] TERM_ADDR = 32'd65532,
  parameter logic [31:0] STAT_ADDR = 32'd65528,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        hit,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;

  logic sel_term;
  logic sel_stat;
  logic wr_term;
  logic wr_stat;
  logic rd_stat;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic flush;

  assign sel_term = (dataadr == TERM_ADDR);
  assign sel_stat = (dataadr == STAT_ADDR);
  assign wr_term  = memwrite & sel_term;
  assign wr_stat  = memwrite & sel_stat;
  assign rd_stat  = memread & sel_stat;
  assign hit      = (memread | memwrite) & (sel_term | sel_stat);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_term & ~full;
  assign pop   = out_valid & out_ready;
  assign flush = wr_stat & writedata[0];

  assign out_data = mem[rd_ptr];
  assign readdata = rd_stat ? {drop_cnt, 6'b0, full, empty, 8'(count)} : '0;

`ifdef CONSOLE_DROP_EN
  logic clr_drop;
  assign clr_drop = wr_stat & writedata[1];
  assign stall    = 1'b0;

  // Count stores discarded because the FIFO was full before the edge; saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (clr_drop) begin
      drop_cnt <= '0;
    end else if (wr_term && full && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign drop_cnt = '0;
  assign stall    = wr_term & full;
`endif

  // FIFO storage; contents need no reset because pointers/count gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= writedata;
    end
  end

  // Pointer and occupancy bookkeeping; flush overrides any same-cycle pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: ACTIVE while entries remain, IDLE once the last one leaves.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (push) state_nxt = ACTIVE;
        ACTIVE:  if (pop && !push && (count == CW'(1))) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: the sink sees valid data whenever the FIFO holds an entry.
  always_comb begin
    out_valid = (state == ACTIVE);
  end

endmodule

// File: tb/tb_console_mmio_ctrl.sv
// Scoreboard bench for console_mmio_ctrl: the driver keeps a queue model of
// the FIFO contents, the monitor compares sink data, status reads, hit and
// stall on every falling edge.
module tb_console_mmio_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] TERM  = 32'd65532;
  localparam logic [31:0] STAT  = 32'd65528;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        out_ready = 1'b0;
  logic [31:0] readdata;
  logic        hit;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_data;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] q[$];
  logic [31:0] rd_q[$];
  logic [15:0] drops = '0;
  logic        exp_hit = 1'b0;
  logic        exp_stall = 1'b0;

  console_mmio_ctrl #(
    .TERM_ADDR(TERM),
    .STAT_ADDR(STAT),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .memwrite(memwrite),
    .memread(memread),
    .dataadr(dataadr),
    .writedata(writedata),
    .readdata(readdata),
    .hit(hit),
    .stall(stall),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_word();
    logic f;
    logic e;
    f = (q.size() == DEPTH);
    e = (q.size() == 0);
    return {drops, 6'b0, f, e, 8'(q.size())};
  endfunction

  // One bus cycle: drive, record expectations, let the edge happen, update model.
  task automatic step(input logic mw, input logic mr, input logic [31:0] adr,
                      input logic [31:0] wd, input logic rdy, output logic acc);
    logic f;
    logic is_term;
    logic is_stat;
    memwrite  = mw;
    memread   = mr;
    dataadr   = adr;
    writedata = wd;
    out_ready = rdy;
    f       = (q.size() == DEPTH);
    is_term = (adr == TERM);
    is_stat = (adr == STAT);
    exp_hit = (mw | mr) & (is_term | is_stat);
`ifdef CONSOLE_DROP_EN
    exp_stall = 1'b0;
`else
    exp_stall = mw & is_term & f;
`endif
    if (mr) rd_q.push_back(is_stat ? status_word() : 32'h0);
    acc = mw & is_term & ~f;
    @(posedge clk);
    if (mw && is_stat && wd[0]) q.delete();
    else if (acc) q.push_back(wd);
`ifdef CONSOLE_DROP_EN
    if (mw && is_term && f && drops != 16'hFFFF) drops++;
`endif
    if (mw && is_stat && wd[1]) drops = '0;
    #1;
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    step(1'b0, 1'b0, 32'h0, 32'h0, rdy, acc);
  endtask

  task automatic stat_read(input logic rdy);
    logic acc;
    step(1'b0, 1'b1, STAT, 32'h0, rdy, acc);
  endtask

  task automatic ctrl_write(input logic [31:0] wd, input logic rdy);
    logic acc;
    step(1'b1, 1'b0, STAT, wd, rdy, acc);
  endtask

  // Store as the hazard unit would: re-present while stalled, bounded.
  task automatic store(input logic [31:0] d, input logic rdy);
    logic acc;
`ifdef CONSOLE_DROP_EN
    step(1'b1, 1'b0, TERM, d, rdy, acc);
`else
    int unsigned n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 32) begin
      step(1'b1, 1'b0, TERM, d, rdy, acc);
      n++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL store_timeout: got stalled, expected accept within 32 cycles (data 0x%08h)", d);
    end
`endif
  endtask

  task automatic do_reset(input logic rdy);
    memwrite  = 1'b0;
    memread   = 1'b0;
    out_ready = rdy;
    exp_hit   = 1'b0;
    exp_stall = 1'b0;
    reset     = 1'b0;
    q.delete();
    rd_q.delete();
    drops = '0;
    #1;
    check("out_valid_in_reset", {31'b0, out_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Monitor: compares DUT outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin : monitor
    check("out_valid", {31'b0, out_valid}, {31'b0, (q.size() != 0)});
    check("hit", {31'b0, hit}, {31'b0, exp_hit});
    check("stall", {31'b0, stall}, {31'b0, exp_stall});
    if (memread && rd_q.size() > 0) check("readdata", readdata, rd_q.pop_front());
    else check("readdata_idle", readdata, 32'h0);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL out_data_unexpected: got 0x%08h, expected no entry", out_data);
      end else begin
        check("out_data", out_data, q.pop_front());
      end
    end
  end

  initial begin : driver
    logic acc;
    logic rdy;
    int unsigned r;
    #2;
    do_reset(1'b0);
    stat_read(1'b0);

    // single character, immediately accepted
    store(32'd42, 1'b1);
    repeat (3) idle(1'b1);

    // fill, status, stall on the 9th, drain in order
    for (int i = 1; i <= 8; i++) store(32'(i), 1'b0);
    stat_read(1'b0);
    step(1'b1, 1'b0, TERM, 32'd9, 1'b0, acc);
    store(32'd9, 1'b1);
    repeat (12) idle(1'b1);

    // full FIFO with continuous push/pop across pointer wrap
    for (int i = 0; i < 8; i++) store(32'(200 + i), 1'b0);
    for (int i = 0; i < 12; i++) store(32'(300 + i), 1'b1);
    stat_read(1'b0);
    repeat (12) idle(1'b1);

    // flush beats a simultaneous pop
    for (int i = 0; i < 3; i++) store(32'(400 + i), 1'b0);
    ctrl_write(32'h1, 1'b1);
    stat_read(1'b1);
    repeat (2) idle(1'b1);

`ifdef CONSOLE_DROP_EN
    for (int i = 0; i < 8; i++) store(32'(500 + i), 1'b0);
    for (int i = 0; i < 3; i++) store(32'(600 + i), 1'b0);
    stat_read(1'b0);
    ctrl_write(32'h2, 1'b0);
    stat_read(1'b0);
    ctrl_write(32'h1, 1'b0);
`endif

    // reset mid-drain
    for (int i = 0; i < 5; i++) store(32'(700 + i), 1'b0);
    idle(1'b0);
    do_reset(1'b1);
    stat_read(1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rdy = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 99);
      if (r < 50)      step(1'b1, 1'b0, TERM, $urandom, rdy, acc);
      else if (r < 65) stat_read(rdy);
      else if (r < 68) ctrl_write(32'h2, rdy);
      else if (r < 70) ctrl_write($urandom, rdy);
      else if (r < 75) step(1'b0, 1'b1, TERM, 32'h0, rdy, acc);
      else if (r < 80) step(1'b1, 1'b0, (r[0] ? 32'd65536 : 32'd65524), $urandom, rdy, acc);
      else if (r < 85) step(1'b0, 1'b1, 32'd65530, 32'h0, rdy, acc);
      else             idle(rdy);
    end
    repeat (12) idle(1'b1);
    stat_read(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
